// File: rtl/stream_cipher_pkg.sv
// Types and default sizing shared by the keystream core, its sequencer and the chip interface FSM.
package stream_cipher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        GEN,
        READY
    } seq_state_t;

    localparam int KS_WARMUP_CYCLES = 64;
    localparam int KS_WORD_W        = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keystream_sequencer_if.sv
// Sequencer bus: chip-FSM handshake plus the bit-serial keystream core strobes.
interface keystream_sequencer_if #(
    parameter int WORD_W = stream_cipher_pkg::KS_WORD_W
);
    logic              start;
    logic              rekey;
    logic [WORD_W-1:0] data_in;
    logic              ks_bit;
    logic              output_acknowledge;
    logic              ks_load;
    logic              ks_step;
    logic [WORD_W-1:0] data_out;
    logic              output_is_ready;
    logic              busy;
    logic              keyed;

    // slave is the sequencer; master is whoever drives it (chip FSM + core)
    modport slave (
        input  start, rekey, data_in, ks_bit, output_acknowledge,
        output ks_load, ks_step, data_out, output_is_ready, busy, keyed
    );

    modport master (
        output start, rekey, data_in, ks_bit, output_acknowledge,
        input  ks_load, ks_step, data_out, output_is_ready, busy, keyed
    );

endinterface

// File: rtl/keystream_sequencer.sv
// Loads and warms up the keystream core, steps it once per keystream bit and
// XORs the assembled LSB-first keystream word with the latched input word.
module keystream_sequencer
    import stream_cipher_pkg::*;
#(
    parameter int WARMUP_CYCLES = KS_WARMUP_CYCLES,
    parameter int WORD_W        = KS_WORD_W
) (
    input  logic                  clk,
    input  logic                  nrst,
    keystream_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(WARMUP_CYCLES, WORD_W) + 1);

    seq_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] ks;
    logic [WORD_W-1:0] data_lat;
    logic [WORD_W-1:0] dout;
    logic              keyed_q;

    // New bits enter at the MSB, so after WORD_W shifts the first one sits at bit 0
    logic [WORD_W:0]   ks_wide;
    logic [WORD_W-1:0] ks_next;
    assign ks_wide = {bus.ks_bit, ks};
    assign ks_next = ks_wide[WORD_W:1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            ks       <= '0;
            data_lat <= '0;
            dout     <= '0;
            keyed_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_lat <= bus.data_in;
                        cnt      <= '0;
                        state    <= (bus.rekey || !keyed_q) ? LOAD : GEN;
                    end
                end
                LOAD: begin
                    keyed_q <= 1'b0;
                    state   <= WARMUP;
                end
                WARMUP: begin
                    if (cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
                        keyed_q <= 1'b1;
                        cnt     <= '0;
                        state   <= GEN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GEN: begin
                    ks <= ks_next;
                    if (cnt == CNT_W'(WORD_W - 1)) begin
                        dout  <= data_lat ^ ks_next;
                        state <= READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (bus.output_acknowledge) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes: no input reaches an output combinationally
    assign bus.ks_load         = (state == LOAD);
    assign bus.ks_step         = (state == WARMUP) || (state == GEN);
    assign bus.output_is_ready = (state == READY);
    assign bus.busy            = (state != IDLE);
    assign bus.keyed           = keyed_q;
    assign bus.data_out        = dout;

endmodule
